// File: rtl/uart_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_tx_if                                                |
// | Purpose  : Byte-request / TX-line bundle between a byte source and   |
// |            the uart_tx serialiser.                                   |
// | Signals  : data       [7:0] byte to send (source -> tx)              |
// |            data_ready       level request to send (source -> tx)     |
// |            done             1 = idle / frame complete (tx -> source) |
// |            serial           TX line, idle-high (tx -> pin)           |
// | Modports : master = byte source, slave = transmitter                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface uart_tx_if;
  logic [7:0] data;
  logic       data_ready;
  logic       done;
  logic       serial;

  modport master (
    output data,
    output data_ready,
    input  done,
    input  serial
  );

  modport slave (
    input  data,
    input  data_ready,
    output done,
    output serial
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_tx                                                   |
// | Purpose  : UART transmitter, 8N1 framing, LSB first. One byte is     |
// |            accepted per IDLE visit while data_ready is high and      |
// |            shifted out with CLK_PER_BIT clocks per bit.              |
// | Ports    : clk              system clock, rising edge               |
// |            rst              synchronous active-high reset           |
// |            bus (slave)      data, data_ready in; done, serial out   |
// | Params   : CLK_PER_BIT      clocks per serial bit, >= 2             |
// | Macro    : UART_TX_PARITY_EN adds an even-parity bit after data     |
// |            bit 7 (11-bit frame); undefined gives plain 8N1.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module uart_tx #(
  parameter int CLK_PER_BIT = 100
) (
  input  wire logic clk,
  input  wire logic rst,
  uart_tx_if.slave  bus
);

  localparam int              c_cnt_w    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_cyc_last = c_cnt_w'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             r_state, w_state;
  logic [c_cnt_w-1:0] r_cyc,   w_cyc;
  logic [2:0]         r_bit,   w_bit;
  logic [7:0]         r_shift, w_shift;
  logic               r_serial, w_serial;
  logic               r_done,   w_done;
  logic               w_bit_end;
  logic               w_accept;

  assign w_bit_end = (r_cyc == c_cyc_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cyc    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_serial <= 1'b1;
      r_done   <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_cyc    <= w_cyc;
      r_bit    <= w_bit;
      r_shift  <= w_shift;
      r_serial <= w_serial;
      r_done   <= w_done;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cyc    = r_cyc;
    w_bit    = r_bit;
    w_shift  = r_shift;
    w_serial = r_serial;
    w_done   = r_done;
    w_accept = 1'b0;

    // Bit-period counter runs only inside a frame and wraps at each bit edge.
    if (r_state != S_IDLE) begin
      w_cyc = w_bit_end ? '0 : r_cyc + 1'b1;
    end

    // serial is registered, so every branch loads the value of the NEXT bit
    // on the edge that ends the current one.
    case (r_state)
      S_IDLE: begin
        w_serial = 1'b1;
        w_done   = 1'b1;
        w_accept = bus.data_ready;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state  = S_DATA;
          w_bit    = 3'd0;
          w_serial = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state  = S_PARITY;
            w_serial = ^r_shift;
`else
            w_state  = S_STOP;
            w_serial = 1'b1;
`endif
          end else begin
            w_bit    = r_bit + 3'd1;
            w_serial = r_shift[w_bit];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state  = S_STOP;
          w_serial = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          // The stop-bit end edge is the first IDLE edge; a request still
          // pending here starts the next frame at once, with no idle gap.
          if (bus.data_ready) begin
            w_accept = 1'b1;
          end else begin
            w_state  = S_IDLE;
            w_done   = 1'b1;
            w_serial = 1'b1;
          end
        end
      end
      default: begin
        w_state  = S_IDLE;
        w_serial = 1'b1;
        w_done   = 1'b1;
      end
    endcase

    // Acceptance edge: latch the byte and drive the start bit immediately.
    if (w_accept) begin
      w_state  = S_START;
      w_shift  = bus.data;
      w_serial = 1'b0;
      w_done   = 1'b0;
      w_bit    = 3'd0;
      w_cyc    = '0;
    end
  end

  assign bus.done   = r_done;
  assign bus.serial = r_serial;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_tx                                                |
// | Purpose  : Self-checking bench for uart_tx. Stimulus pushes expected |
// |            frames (byte + acceptance cycle) into a scoreboard queue; |
// |            a monitor pops them when a start bit appears and checks   |
// |            every bit against a frame built from the framing rules.   |
// | Macro    : UART_TX_PARITY_EN selects the 11-bit parity frame.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_uart_tx;

  localparam int CPB = 100;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  typedef struct {
    logic [7:0] b;
    int         e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   abort = 1'b0;
  int   model_idle = 0;
  exp_t q[$];

  uart_tx_if u_if ();

  uart_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level for bit slot k of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    logic [NB-1:0] f;
`ifdef UART_TX_PARITY_EN
    f = {1'b1, ^b, b, 1'b0};
`else
    f = {1'b1, b, 1'b0};
`endif
    return f[k];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input logic [7:0] b, input int e0);
    exp_t e;
    e.b  = b;
    e.e0 = e0;
    q.push_back(e);
  endtask

  // Request one frame; data_ready is held for 'hold' acceptance-side edges.
  task automatic send(input logic [7:0] b, input int hold, output int e0);
    wait_to(model_idle - 1);
    e0 = cyc + 1;
    u_if.data       = b;
    u_if.data_ready = 1'b1;
    push(b, e0);
    model_idle = e0 + FRAME;
    repeat (hold) tick();
    u_if.data_ready = 1'b0;
    u_if.data       = 8'($urandom);
  endtask

  // Two frames from one continuous request; second starts exactly at frame end.
  task automatic send_b2b(input logic [7:0] b1, input logic [7:0] b2);
    int e0;
    wait_to(model_idle - 1);
    e0 = cyc + 1;
    u_if.data       = b1;
    u_if.data_ready = 1'b1;
    push(b1, e0);
    tick();
    u_if.data = b2;
    push(b2, e0 + FRAME);
    wait_to(e0 + FRAME - 1);
    tick();
    u_if.data_ready = 1'b0;
    u_if.data       = 8'($urandom);
    model_idle = e0 + 2 * FRAME;
  endtask

  // Monitor: detects start bits, pops the scoreboard and checks the frame.
  initial begin : mon
    exp_t cur;
    int   e0;
    int   t;
    bit   chain;
    bit   aborted;
    forever begin
      @(negedge clk);
      if (abort || rst || u_if.serial !== 1'b0) continue;
      chk("frame_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() == 0) begin
        repeat (FRAME) @(negedge clk);
        continue;
      end
      cur = q.pop_front();
      chk("start_edge", cyc, cur.e0);
      e0      = cyc;
      chain   = 1'b1;
      aborted = 1'b0;
      while (chain && !aborted) begin
        chain = 1'b0;
        for (int k = 0; k < NB && !aborted; k++) begin
          for (int s = 0; s < 3; s++) begin
            t = e0 + k * CPB + ((s == 0) ? 0 : (s == 1) ? CPB / 2 : CPB - 1);
            while (cyc < t && !abort) @(negedge clk);
            if (abort) begin
              aborted = 1'b1;
              break;
            end
            chk($sformatf("bit%0d_byte%0h", k, cur.b), 32'(u_if.serial), 32'(exp_bit(cur.b, k)));
            chk("done_low_in_frame", 32'(u_if.done), 32'd0);
          end
        end
        if (aborted) break;
        while (cyc < e0 + FRAME && !abort) @(negedge clk);
        if (abort) begin
          aborted = 1'b1;
          break;
        end
        if (q.size() > 0 && q[0].e0 == e0 + FRAME) begin
          chk("b2b_start_serial", 32'(u_if.serial), 32'd0);
          chk("b2b_start_done", 32'(u_if.done), 32'd0);
          cur   = q.pop_front();
          e0    = e0 + FRAME;
          chain = 1'b1;
        end else begin
          chk("end_serial", 32'(u_if.serial), 32'd1);
          chk("end_done", 32'(u_if.done), 32'd1);
        end
      end
      while (abort) @(negedge clk);
    end
  end

  initial begin : watchdog
    #(10 * 200000);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e0;
    u_if.data       = 8'h00;
    u_if.data_ready = 1'b0;
    rst             = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    // Idle after reset with no request.
    for (int i = 0; i < 30; i++) begin
      chk("reset_serial", 32'(u_if.serial), 32'd1);
      chk("reset_done", 32'(u_if.done), 32'd1);
      tick();
    end
    model_idle = cyc + 1;

    send(8'hFF, 3, e0);
    send(8'h55, 1, e0);
    send(8'h00, 5, e0);
    send(8'h07, 2, e0);
    repeat (3) tick();
    send_b2b(8'hA5, 8'h3C);

    // Mid-frame reset aborts the frame; a later request sends cleanly.
    send(8'hC3, 2, e0);
    wait_to(e0 + 449);
    rst   = 1'b1;
    abort = 1'b1;
    tick();
    chk("abort_serial", 32'(u_if.serial), 32'd1);
    chk("abort_done", 32'(u_if.done), 32'd1);
    rst   = 1'b0;
    abort = 1'b0;
    model_idle = cyc + 1;
    repeat (4) tick();
    send(8'h81, 1, e0);

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 3) == 0)
        send_b2b(8'($urandom), 8'($urandom));
      else
        send(8'($urandom), $urandom_range(1, 40), e0);
    end

    wait_to(model_idle + 20);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("final_serial", 32'(u_if.serial), 32'd1);
    chk("final_done", 32'(u_if.done), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
